rr_arbiter_n: RTL and testbench
===============================

// Module: rr_arbiter_n
// PURPOSE
//   Parametrised N-requester round-robin arbiter; successor to the 3-request Moore arbiter.
//   Registered one-hot grant with rotating priority pointer.
//   Configurable grant hold (burst) length.
//   Sits between N bus masters and one shared resource; grant drives the resource-side mux select.
// PARAMETERS
//   N         3   number of requesters (N >= 2)
//   MAX_HOLD  1   max consecutive cycles one requester keeps the grant while others wait (>= 1)
//   ID_W      -   localparam = $clog2(N), width of gnt_id
// PORTS
//   clk        in   1     clock, all state updates on rising edge
//   reset      in   1     synchronous, active-low reset
//   req        in   N     request vector, bit i = requester i, level-sensitive
//   urgent     in   N     urgent qualifier per requester (only with RR_ARB_URGENT_EN)
//   gnt        out  N     registered one-hot grant, all-zero = idle
//   gnt_valid  out  1     registered, = |gnt
//   gnt_id     out  ID_W  registered binary index of granted requester, 0 when idle
// BEHAVIOUR
//   Reset: reset, synchronous, active-low; clock clk.
//   - reset==0 at edge: gnt=0, gnt_valid=0, gnt_id=0, ptr=N-1, hold_cnt=0.
//   - Applies mid-grant: grant drops at that edge, no completion of hold.
//   Latency: req sampled at edge k -> gnt/gnt_valid/gnt_id valid after edge k (1 cycle).
//     Outputs come from registers only (Moore).
//   State: gnt (one-hot/zero), ptr (index of last granted, ID_W bits), hold_cnt (0..MAX_HOLD-1).
//   Next-state, evaluated each edge with reset==1:
//   1. HOLD: gnt valid, req[gnt_id]==1 and hold_cnt < MAX_HOLD-1 -> keep gnt, hold_cnt+1.
//   2. ROTATE: otherwise search req circularly from ptr+1 (mod N) through ptr.
//      - First set bit wins -> gnt=that bit, ptr=its index, hold_cnt=0.
//      - Current holder wins again only if no other bit is set (search reaches ptr last).
//   3. IDLE: req==0 -> gnt=0, gnt_id=0, hold_cnt=0, ptr unchanged.
//   Boundary conditions:
//   - After reset ptr=N-1, so first search starts at index 0: lowest index wins from cold idle.
//   - Wrap: ptr==N-1 -> search starts at 0; ptr+1 computed mod N, valid for non-power-of-2 N.
//   - Holder drops req mid-hold -> rotate at next edge, no dead cycle unless req==0.
//   - MAX_HOLD==1: rotate every cycle among requesters (3-request behaviour for N=3).
//   - Fairness: any continuously asserted req is granted within (N-1)*MAX_HOLD+1 cycles.
//   - Never more than one gnt bit set; gnt bit only set for a req bit high at the sampling edge.
// CONFIGURATION
//   RR_ARB_URGENT_EN defined:
//   - urgent port present; U = req & urgent.
//   - If U != 0, the round-robin search from ptr+1 runs over U only.
//   - Pre-empts an active HOLD of a non-urgent holder at the next edge.
//   - An urgent holder still obeys MAX_HOLD among urgent requesters.
//   - ptr/hold_cnt update as in ROTATE.
//   RR_ARB_URGENT_EN undefined:
//   - urgent port absent; arbitration purely as BEHAVIOUR above.
// TESTING
//   1. Reset: reset=0 for 3 cycles, req=111 -> gnt=000, gnt_valid=0; release -> gnt=001, gnt_id=0 next edge.
//   2. N=3, MAX_HOLD=1, req=111 constant -> gnt 001,010,100,001,... one step per cycle.
//   3. N=3, MAX_HOLD=1, req[1:0]=11 always, req[2] raised while gnt=001 -> gnt=010 then 100 (<=2 cycles).
//   4. MAX_HOLD=4, req=001 for 2 cycles then 011 -> gnt=001 for 4 cycles total, then 010.
//   5. N=5, req=10001 with gnt=10000 (ptr=4) -> wrap, gnt=00001; req->00000 -> gnt=0, gnt_valid=0 next edge.
//   6. RR_ARB_URGENT_EN, MAX_HOLD=4: gnt=001 holding, req=111, urgent=100 -> gnt=100 at next edge.
//   7. Reset mid-hold: reset=0 while gnt=010, hold_cnt=2 -> gnt=0 next edge; after release first grant is 001.

Source files
------------

// File: rtl/rr_arbiter_n_if.sv
// Request/grant bundle between N bus masters and the round-robin arbiter.
// The urgent vector exists only when RR_ARB_URGENT_EN is defined.
interface rr_arbiter_n_if #(
    parameter int unsigned N = 3
);
    localparam int unsigned ID_W = $clog2(N);

    logic [N-1:0]    req;
`ifdef RR_ARB_URGENT_EN
    logic [N-1:0]    urgent;
`endif
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [ID_W-1:0] gnt_id;

`ifdef RR_ARB_URGENT_EN
    modport master (output req, output urgent, input gnt, input gnt_valid, input gnt_id);
    modport slave  (input req, input urgent, output gnt, output gnt_valid, output gnt_id);
`else
    modport master (output req, input gnt, input gnt_valid, input gnt_id);
    modport slave  (input req, output gnt, output gnt_valid, output gnt_id);
`endif
endinterface

// File: rtl/rr_arbiter_n.sv
// N-requester round-robin arbiter: registered one-hot grant, rotating pointer, burst hold.
// Define RR_ARB_URGENT_EN to restrict arbitration to urgent requesters when any are present.
module rr_arbiter_n #(
    parameter int unsigned N        = 3,
    parameter int unsigned MAX_HOLD = 1
) (
    input  logic          clk,
    input  logic          reset,
    rr_arbiter_n_if.slave bus
);
    localparam int unsigned ID_W = $clog2(N);
    localparam int unsigned HW   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [N-1:0]    r_gnt;
    logic            r_gnt_valid;
    logic [ID_W-1:0] r_gnt_id;
    logic [ID_W-1:0] r_ptr;
    logic [HW-1:0]   r_hold;

    logic [N-1:0]    w_cand;
    logic            w_hold_blk;
    logic            w_hold_ok;
    logic            w_found;
    logic [ID_W-1:0] w_win;
    logic [N-1:0]    w_gnt_nxt;
    logic            w_valid_nxt;
    logic [ID_W-1:0] w_id_nxt;
    logic [ID_W-1:0] w_ptr_nxt;
    logic [HW-1:0]   w_hold_nxt;

`ifdef RR_ARB_URGENT_EN
    logic [N-1:0] w_urg;
    assign w_urg      = bus.req & bus.urgent;
    assign w_cand     = (|w_urg) ? w_urg : bus.req;
    // A non-urgent holder loses its burst as soon as any urgent request appears.
    assign w_hold_blk = (|w_urg) && !bus.urgent[r_gnt_id];
`else
    assign w_cand     = bus.req;
    assign w_hold_blk = 1'b0;
`endif

    assign w_hold_ok = r_gnt_valid && bus.req[r_gnt_id] && !w_hold_blk &&
                       (32'(r_hold) + 32'd1 < MAX_HOLD);

    // Circular search from ptr+1; the last grantee is visited last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 1; i <= int'(N); i++) begin
            if (!w_found && w_cand[(int'(r_ptr) + i) % int'(N)]) begin
                w_found = 1'b1;
                w_win   = ID_W'((int'(r_ptr) + i) % int'(N));
            end
        end
    end

    always_comb begin
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_id_nxt    = '0;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = '0;
        if (w_hold_ok) begin
            w_gnt_nxt   = r_gnt;
            w_valid_nxt = 1'b1;
            w_id_nxt    = r_gnt_id;
            w_hold_nxt  = r_hold + HW'(1);
        end else if (w_found) begin
            w_gnt_nxt[w_win] = 1'b1;
            w_valid_nxt      = 1'b1;
            w_id_nxt         = w_win;
            w_ptr_nxt        = w_win;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_ptr       <= ID_W'(N - 1);
            r_hold      <= '0;
        end else begin
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= w_valid_nxt;
            r_gnt_id    <= w_id_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold      <= w_hold_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.gnt_id    = r_gnt_id;
endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n: three instances (N=3/MAX_HOLD=1, N=3/MAX_HOLD=4, N=5/MAX_HOLD=1).
module tb_rr_arbiter_n;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    rr_arbiter_n_if #(.N(3)) a_if ();
    rr_arbiter_n_if #(.N(3)) b_if ();
    rr_arbiter_n_if #(.N(5)) c_if ();

    rr_arbiter_n #(.N(3), .MAX_HOLD(1)) u_a (.clk(clk), .reset(reset), .bus(a_if));
    rr_arbiter_n #(.N(3), .MAX_HOLD(4)) u_b (.clk(clk), .reset(reset), .bus(b_if));
    rr_arbiter_n #(.N(5), .MAX_HOLD(1)) u_c (.clk(clk), .reset(reset), .bus(c_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected valid and id follow from the expected one-hot grant.
    task automatic ck_a(input string tag, input int unsigned eg, input int unsigned eid);
        chk({tag, ".gnt"}, 32'(a_if.gnt), eg);
        chk({tag, ".vld"}, 32'(a_if.gnt_valid), (eg != 0) ? 1 : 0);
        chk({tag, ".id"}, 32'(a_if.gnt_id), eid);
    endtask

    task automatic ck_b(input string tag, input int unsigned eg, input int unsigned eid);
        chk({tag, ".gnt"}, 32'(b_if.gnt), eg);
        chk({tag, ".vld"}, 32'(b_if.gnt_valid), (eg != 0) ? 1 : 0);
        chk({tag, ".id"}, 32'(b_if.gnt_id), eid);
    endtask

    task automatic ck_c(input string tag, input int unsigned eg, input int unsigned eid);
        chk({tag, ".gnt"}, 32'(c_if.gnt), eg);
        chk({tag, ".vld"}, 32'(c_if.gnt_valid), (eg != 0) ? 1 : 0);
        chk({tag, ".id"}, 32'(c_if.gnt_id), eid);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        a_if.req = 3'b111;
        b_if.req = 3'b000;
        c_if.req = 5'b00000;
`ifdef RR_ARB_URGENT_EN
        a_if.urgent = '0;
        b_if.urgent = '0;
        c_if.urgent = '0;
`endif
        // Reset held with requests pending
        repeat (3) tick();
        ck_a("rst_a", 'b000, 0);
        ck_b("rst_b", 'b000, 0);
        reset = 1'b1;
        tick();
        ck_a("cold", 'b001, 0);

        // Full rotation with all requesting
        tick(); ck_a("rot1", 'b010, 1);
        tick(); ck_a("rot2", 'b100, 2);
        tick(); ck_a("rot3", 'b001, 0);

        // Late requester 2 served within two cycles
        a_if.req = 3'b011;
        tick(); ck_a("two1", 'b010, 1);
        tick(); ck_a("two2", 'b001, 0);
        a_if.req = 3'b111;
        tick(); ck_a("late1", 'b010, 1);
        tick(); ck_a("late2", 'b100, 2);
        a_if.req = 3'b000;

        // Burst hold of four cycles, then rotate
        b_if.req = 3'b001;
        tick(); ck_b("hold0", 'b001, 0);
        tick(); ck_b("hold1", 'b001, 0);
        b_if.req = 3'b011;
        tick(); ck_b("hold2", 'b001, 0);
        tick(); ck_b("hold3", 'b001, 0);
        tick(); ck_b("hold_rot", 'b010, 1);

        // Holder drops its request: immediate handover, no idle cycle
        b_if.req = 3'b001;
        tick(); ck_b("drop", 'b001, 0);
        tick(); ck_b("drop_h1", 'b001, 0);
        b_if.req = 3'b111;
`ifdef RR_ARB_URGENT_EN
        b_if.urgent = 3'b100;
        tick(); ck_b("urgent", 'b100, 2);
        b_if.urgent = 3'b000;
`else
        tick(); ck_b("no_urgent", 'b001, 0);
`endif

        // N=5 wrap from ptr 4 back to 0, then idle
        c_if.req = 5'b10000;
        tick(); ck_c("c_top", 'b10000, 4);
        c_if.req = 5'b10001;
        tick(); ck_c("c_wrap", 'b00001, 0);
        tick(); ck_c("c_back", 'b10000, 4);
        c_if.req = 5'b00000;
        tick(); ck_c("c_idle", 'b00000, 0);

        // Reset in the middle of a hold
        b_if.req = 3'b010;
        tick(); ck_b("mh0", 'b010, 1);
        tick(); ck_b("mh1", 'b010, 1);
        tick(); ck_b("mh2", 'b010, 1);
        reset = 1'b0;
        tick(); ck_b("mh_rst", 'b000, 0);
        reset = 1'b1;
        b_if.req = 3'b111;
        tick(); ck_b("mh_after", 'b001, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
